// File: rtl/operand_entry_fsm_if.sv
// Operand entry bundle: switch/button inputs toward the capture stage and the
// captured operand pair back out to the downstream logic units.
interface operand_entry_fsm_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] sw_in;
  logic             btn_load;
  logic             btn_clear;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             valid;
  logic [1:0]       state_o;

  modport master (
    output sw_in, btn_load, btn_clear,
    input  A, B, valid, state_o
  );

  modport slave (
    input  sw_in, btn_load, btn_clear,
    output A, B, valid, state_o
  );
endinterface

// File: rtl/operand_entry_fsm.sv
// Two-press operand capture for the 4-bit logic units: a debounced load button
// captures A and then B; valid marks the pair as stable downstream.
module operand_entry_fsm #(
  parameter int WIDTH     = 4,
  parameter int DB_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  operand_entry_fsm_if.slave   io
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GOT_A = 2'b01,
    READY = 2'b10,
    BAD   = 2'b11
  } state_e;

  logic [CW-1:0]    cnt_q, cnt_d;
  logic             db_q, db_d;
  logic             db_prev_q;
  logic             press_s;
  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             valid_q;

  // Debounce next-state: count consecutive mismatching samples, toggle on the last one
  always_comb begin
    cnt_d = '0;
    db_d  = db_q;
    if (io.btn_load != db_q) begin
      if (cnt_q == CNT_LAST) begin
        db_d  = ~db_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  // Debounce state registers and the edge-detect history
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      db_q      <= 1'b0;
      db_prev_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      db_q      <= db_d;
      db_prev_q <= db_q;
    end
  end

  assign press_s = db_q & ~db_prev_q;

  // Operand FSM; clear wins over a press completing on the same edge
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      valid_q <= 1'b0;
    end else if (io.btn_clear) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (press_s) begin
            a_q     <= io.sw_in;
            state_q <= GOT_A;
          end else begin
            state_q <= IDLE;
          end
        end
        GOT_A: begin
          if (press_s) begin
            b_q     <= io.sw_in;
            valid_q <= 1'b1;
            state_q <= READY;
          end else begin
            state_q <= GOT_A;
          end
        end
        READY: begin
          if (press_s) begin
            a_q     <= io.sw_in;
            b_q     <= '0;
            valid_q <= 1'b0;
            state_q <= GOT_A;
          end else begin
            state_q <= READY;
          end
        end
        default: begin
          state_q <= IDLE;
          a_q     <= '0;
          b_q     <= '0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign io.A       = a_q;
  assign io.B       = b_q;
  assign io.valid   = valid_q;
  assign io.state_o = state_q;

endmodule

// File: tb/tb_operand_entry_fsm.sv
// Bench for operand_entry_fsm: directed scenarios plus random button traffic,
// all checked against a sample-history reference model.
module tb_operand_entry_fsm;
  localparam int W  = 4;
  localparam int DB = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  operand_entry_fsm_if #(.WIDTH(W)) io ();
  operand_entry_fsm #(.WIDTH(W), .DB_CYCLES(DB)) dut (.clk(clk), .rst(rst), .io(io));

  int vectors = 0;
  int miscompares = 0;

  // reference model: last DB raw samples, accepted level, and operand entry count
  bit           hist[$];
  bit           lvl, lvl_prev;
  int           phase;
  logic [W-1:0] ea, eb;
  logic         ev;

  logic [2*W+2:0] got;
  assign got = {io.A, io.B, io.valid, io.state_o};

  function automatic logic [2*W+2:0] exp_vec();
    return {ea, eb, ev, 2'(phase)};
  endfunction

  function void model_step(bit r, bit btn, bit clr, logic [W-1:0] sw);
    bit press, all_diff;
    if (r) begin
      hist.delete(); lvl = 0; lvl_prev = 0; phase = 0; ea = '0; eb = '0; ev = 0;
      return;
    end
    press = lvl && !lvl_prev;
    if (clr) begin
      phase = 0; ea = '0; eb = '0; ev = 0;
    end else if (press) begin
      if (phase == 0)      begin ea = sw; phase = 1; end
      else if (phase == 1) begin eb = sw; ev = 1; phase = 2; end
      else                 begin ea = sw; eb = '0; ev = 0; phase = 1; end
    end
    lvl_prev = lvl;
    hist.push_back(btn);
    if (hist.size() > DB) void'(hist.pop_front());
    if (hist.size() == DB) begin
      all_diff = 1;
      foreach (hist[k]) if (hist[k] == lvl) all_diff = 0;
      if (all_diff) lvl = !lvl;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step(rst, io.btn_load, io.btn_clear, io.sw_in);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; io.btn_load = 1'b1; io.btn_clear = 1'b0; io.sw_in = 4'h9;
    tick(); tick();
    vectors++;
    if (got !== {4'h0, 4'h0, 1'b0, 2'b00}) begin
      miscompares++;
      $display("FAIL reset: got %h want %h", got, {4'h0, 4'h0, 1'b0, 2'b00});
    end
    rst = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      vectors++;
      if (io.state_o !== ((i == 5) ? 2'b01 : 2'b00) || got !== exp_vec()) begin
        miscompares++;
        $display("FAIL reset_release edge %0d: got %h want %h", i, got, exp_vec());
      end
    end
    io.btn_load = 1'b0;
    for (int i = 0; i < 6; i++) tick();
  endtask

  task automatic press_for(input logic [W-1:0] sw, input int n, input string tag);
    io.sw_in = sw; io.btn_load = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
      vectors++;
      if (got !== exp_vec()) begin
        miscompares++;
        $display("FAIL %s edge %0d: got %h want %h", tag, i + 1, got, exp_vec());
      end
    end
    io.btn_load = 1'b0;
    for (int i = 0; i < 6; i++) tick();
  endtask

  task automatic do_clear();
    io.btn_clear = 1'b1; tick(); io.btn_clear = 1'b0;
  endtask

  task automatic test_normal_entry();
    do_clear();
    io.sw_in = 4'hA; io.btn_load = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    vectors++;
    if ({io.A, io.state_o} !== {4'hA, 2'b01}) begin
      miscompares++;
      $display("FAIL normal_A: got A=%h st=%b want A=a st=01", io.A, io.state_o);
    end
    tick();
    io.btn_load = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    press_for(4'h5, 6, "normal_B");
    vectors++;
    if (got !== {4'hA, 4'h5, 1'b1, 2'b10}) begin
      miscompares++;
      $display("FAIL normal_pair: got %h want %h", got, {4'hA, 4'h5, 1'b1, 2'b10});
    end
  endtask

  task automatic test_bounce();
    logic [12:0] pat;
    do_clear();
    pat = 13'b1_1111_0111_0111;  // applied LSB first: 1,1,1,0,1,1,1,0 then 1,1,1,1,1
    io.sw_in = 4'h6;
    for (int i = 0; i < 13; i++) begin
      io.btn_load = pat[i];
      tick();
      vectors++;
      if (io.state_o !== ((i == 12) ? 2'b01 : 2'b00) || got !== exp_vec()) begin
        miscompares++;
        $display("FAIL bounce edge %0d: got %h want %h", i + 1, got, exp_vec());
      end
    end
    io.btn_load = 1'b0;
    for (int i = 0; i < 6; i++) tick();
  endtask

  task automatic test_held();
    int captures;
    logic [1:0] last;
    do_clear();
    captures = 0; last = io.state_o;
    io.sw_in = 4'hC; io.btn_load = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (io.state_o !== last) captures++;
      last = io.state_o;
      io.sw_in = 4'($urandom);
    end
    vectors++;
    if (captures !== 1 || got !== exp_vec()) begin
      miscompares++;
      $display("FAIL held: captures=%0d want 1, got %h want %h", captures, got, exp_vec());
    end
    io.btn_load = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    press_for(4'h2, 6, "held_next");
    vectors++;
    if (io.state_o !== 2'b10 || io.B !== 4'h2) begin
      miscompares++;
      $display("FAIL held_next: got st=%b B=%h want st=10 B=2", io.state_o, io.B);
    end
  endtask

  task automatic test_reentry();
    do_clear();
    press_for(4'hA, 6, "reentry_A");
    press_for(4'h5, 6, "reentry_B");
    press_for(4'h3, 6, "reentry_new");
    vectors++;
    if (got !== {4'h3, 4'h0, 1'b0, 2'b01}) begin
      miscompares++;
      $display("FAIL reentry: got %h want %h", got, {4'h3, 4'h0, 1'b0, 2'b01});
    end
  endtask

  task automatic test_clear_priority();
    do_clear();
    press_for(4'hA, 6, "clrpri_A");
    io.sw_in = 4'h7; io.btn_load = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    io.btn_clear = 1'b1;
    tick();
    io.btn_clear = 1'b0;
    vectors++;
    if (got !== {4'h0, 4'h0, 1'b0, 2'b00}) begin
      miscompares++;
      $display("FAIL clear_priority: got %h want %h", got, {4'h0, 4'h0, 1'b0, 2'b00});
    end
    for (int i = 0; i < 10; i++) tick();
    vectors++;
    if (got !== {4'h0, 4'h0, 1'b0, 2'b00} || got !== exp_vec()) begin
      miscompares++;
      $display("FAIL clear_hold: got %h want %h", got, {4'h0, 4'h0, 1'b0, 2'b00});
    end
    io.btn_load = 1'b0;
    for (int i = 0; i < 6; i++) tick();
  endtask

  task automatic test_random();
    int run;
    run = 0;
    for (int i = 0; i < 1500; i++) begin
      if (run == 0) begin
        io.btn_load = 1'($urandom);
        run = $urandom_range(1, 8);
      end
      run--;
      io.sw_in     = 4'($urandom);
      io.btn_clear = ($urandom_range(0, 39) == 0);
      rst          = ($urandom_range(0, 149) == 0);
      tick();
      vectors++;
      if (got !== exp_vec()) begin
        miscompares++;
        $display("FAIL random cycle %0d: got %h want %h", i, got, exp_vec());
      end
    end
    rst = 1'b0; io.btn_clear = 1'b0;
  endtask

  initial begin
    rst = 1'b1; io.sw_in = '0; io.btn_load = 1'b0; io.btn_clear = 1'b0;
    test_reset();
    test_normal_entry();
    test_bounce();
    test_held();
    test_reentry();
    test_clear_priority();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
